// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity-mode codes,
// one-hot FSM state encoding and small helpers shared with the transmitter.
package uart_rx_cfg_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Below this the half-bit point collapses onto the start-detect latency.
  localparam int MIN_DIV = 3;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_DONE   = 6'b100000
  } state_t;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sync.sv
// Two-flop synchronizer for signals arriving from outside the clk domain.
module uart_rx_cfg_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, runtime parity, 1/2 stop bits,
// false-start rejection, per-frame error status and a valid/ready output register.
import uart_rx_cfg_pkg::*;

module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 enable,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_par_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int BCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t               state_reg, state_next;
  logic                 rx_s;
  logic [DIV_W-1:0]     cnt_reg;
  logic [DIV_W-1:0]     div_reg;
  logic [1:0]           par_mode_reg;
  logic                 two_stop_reg;
  logic [BCNT_W-1:0]    bcnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 pbit_reg;
  logic                 stop1_reg;
  logic                 stop_second_reg;
  logic                 frame_err_reg;
  logic                 par_err_reg;
  logic                 armed_reg;

  logic [DIV_W-1:0]     div_clamped;
  logic [DIV_W-1:0]     half;
  logic                 tick_full;
  logic                 frame_start;
  logic                 bit_tick;
  logic                 break_now;

  uart_rx_cfg_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign div_clamped = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign half        = div_reg >> 1;
  assign tick_full   = (cnt_reg == div_reg);
  assign frame_start = (state_reg == ST_IDLE) && (state_next == ST_START);
  assign bit_tick    = tick_full &&
                       ((state_reg == ST_DATA) || (state_reg == ST_PARITY) ||
                        (state_reg == ST_STOP));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:
        if (enable && !rx_s && armed_reg) state_next = ST_START;
      ST_START:
        if (cnt_reg == half) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (tick_full && (bcnt_reg == BCNT_W'(DATA_BITS - 1)))
          state_next = parity_on(par_mode_reg) ? ST_PARITY : ST_STOP;
      ST_PARITY:
        if (tick_full) state_next = ST_STOP;
      ST_STOP:
        if (tick_full && (!two_stop_reg || stop_second_reg)) state_next = ST_DONE;
      ST_DONE:
        state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
    if (!enable) state_next = ST_IDLE;
  end

  // Bit timer restarts on each state change and after every in-state sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cnt_reg <= '0;
    else if ((state_next != state_reg) || bit_tick) cnt_reg <= '0;
    else                                         cnt_reg <= cnt_reg + 1'b1;
  end

  // ------------------------------------------------------- frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg         <= DIV_W'(MIN_DIV);
      par_mode_reg    <= PAR_NONE;
      two_stop_reg    <= 1'b0;
      bcnt_reg        <= '0;
      shift_reg       <= '0;
      pbit_reg        <= 1'b0;
      stop1_reg       <= 1'b1;
      stop_second_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      par_err_reg     <= 1'b0;
    end else if (frame_start) begin
      div_reg         <= div_clamped;
      par_mode_reg    <= parity_mode;
      two_stop_reg    <= two_stop;
      bcnt_reg        <= '0;
      pbit_reg        <= 1'b0;
      stop1_reg       <= 1'b1;
      stop_second_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      par_err_reg     <= 1'b0;
    end else if (bit_tick) begin
      case (state_reg)
        ST_DATA: begin
          shift_reg[bcnt_reg] <= rx_s;
          bcnt_reg            <= bcnt_reg + 1'b1;
        end
        ST_PARITY: begin
          pbit_reg    <= rx_s;
          par_err_reg <= ((^shift_reg) ^ rx_s) != (par_mode_reg == PAR_ODD);
        end
        ST_STOP: begin
          if (!rx_s)            frame_err_reg <= 1'b1;
          if (!stop_second_reg) stop1_reg     <= rx_s;
          stop_second_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A frame that ends with the line still low must not retrigger until it idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      armed_reg <= 1'b1;
    else if (rx_s)                   armed_reg <= 1'b1;
    else if (state_reg == ST_DONE)   armed_reg <= 1'b0;
  end

  assign break_now = (shift_reg == '0) &&
                     (!parity_on(par_mode_reg) || !pbit_reg) && !stop1_reg;

  // ------------------------------------------------------ output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
      rx_break     <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (state_reg == ST_DONE) begin
        if (!rx_valid || rx_ready) begin
          rx_data      <= shift_reg;
          rx_frame_err <= frame_err_reg;
          rx_par_err   <= par_err_reg;
          rx_break     <= break_now;
          rx_valid     <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed vector table, corner-case
// sequences and randomized frames against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          enable = 1'b0;
  logic [15:0]   clk_div = 16'd15;
  logic [1:0]    parity_mode = 2'd0;
  logic          two_stop = 1'b0;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_frame_err, rx_par_err, rx_break, rx_overrun;

  uart_rx_cfg #(.DATA_BITS(DB), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .enable       (enable),
    .clk_div      (clk_div),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_par_err   (rx_par_err),
    .rx_break     (rx_break),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: handshakes, overrun pulses, rx_valid rise time.
  int          xfers = 0;
  int          ovr_pulses = 0;
  int unsigned rise_cyc = 0;
  logic        valid_d = 1'b0;
  logic [7:0]  last_data = 8'h00;
  logic        last_fe = 1'b0, last_pe = 1'b0, last_brk = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && !valid_d) rise_cyc = cyc;
    valid_d = rx_valid;
    if (rx_overrun) ovr_pulses++;
    if (rx_valid && rx_ready) begin
      xfers++;
      last_data = rx_data;
      last_fe   = rx_frame_err;
      last_pe   = rx_par_err;
      last_brk  = rx_break;
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] pm;
    logic       pbit;
    logic       s1;
    logic       two;
    logic       s2;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
    logic       ebrk;
  } vec_t;

  // Frame-level reference: count ones, look at the stop bits as sent.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] pm,
                                 input logic pbit, input logic s1,
                                 input logic two, input logic s2);
    exp_t e;
    int   ones;
    bit   par_on;
    ones   = $countones(d) + int'(pbit);
    par_on = (pm == 2'd1) || (pm == 2'd2);
    e.data = d;
    e.pe   = par_on && ((ones % 2) != ((pm == 2'd2) ? 1 : 0));
    e.fe   = !s1 || (two && !s2);
    e.brk  = (d == 8'h00) && (!par_on || !pbit) && !s1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int period();
    return ((clk_div < 16'd3) ? 3 : int'(clk_div)) + 1;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                            input logic s1, input logic two, input logic s2,
                            input int per, output int unsigned t0);
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (per) @(negedge clk);
    end
    if (has_par) begin
      rx = pbit;
      repeat (per) @(negedge clk);
    end
    rx = s1;
    repeat (per) @(negedge clk);
    if (two) begin
      rx = s2;
      repeat (per) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_word(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: rx_valid=0, expected 1 within 5000 clk", tag);
    end
  endtask

  task automatic accept(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({tag, " valid_clear"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                           input logic pbit, input logic s1, input logic two,
                           input logic s2, input exp_t e);
    int          per, half, fb, lat;
    int unsigned t0;
    bit          ok, par_on;
    per    = period();
    half   = (per - 1) / 2;
    par_on = (pm == 2'd1) || (pm == 2'd2);
    fb     = 1 + DB + (par_on ? 1 : 0) + (two ? 2 : 1);
    parity_mode = pm;
    two_stop    = two;
    send_frame(d, par_on, pbit, s1, two, s2, per, t0);
    wait_word(tag, ok);
    if (ok) begin
      $display("%s: div=%0d pm=%0d two=%0d data=%02h pe=%0d fe=%0d brk=%0d", tag,
               clk_div, pm, two, rx_data, rx_par_err, rx_frame_err, rx_break);
      chk({tag, " data"}, 32'(rx_data), 32'(e.data));
      chk({tag, " par_err"}, 32'(rx_par_err), 32'(e.pe));
      chk({tag, " frame_err"}, 32'(rx_frame_err), 32'(e.fe));
      chk({tag, " break"}, 32'(rx_break), 32'(e.brk));
      lat = int'(rise_cyc - t0);
      chk_range({tag, " latency"}, lat, 3 + half + (fb - 1) * per, 5 + half + (fb - 1) * per);
      accept(tag);
    end
    repeat (2 * per) @(negedge clk);
  endtask

  vec_t        tbl [11];
  exp_t        e;
  int unsigned t0;
  int          x0, o0;
  bit          ok;
  logic [7:0]  d;
  logic [1:0]  pm;
  logic        two, good, pbit, s1, s2;

  initial begin
    //                d      pm    pbit  s1    two   s2    ed     pe    fe    brk
    tbl[0]  = '{8'hA5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h07, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8'h07, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h3C, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{8'h00, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'h80, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'hFF, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset rx_data", 32'(rx_data), 32'd0);
    chk("reset flags", {29'd0, rx_frame_err, rx_par_err, rx_break}, 32'd0);
    chk("reset overrun", 32'(rx_overrun), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("post-reset rx_valid", 32'(rx_valid), 32'd0);

    // Directed table, clk_div=15
    clk_div = 16'd15;
    for (int i = 0; i < 11; i++) begin
      e = '{tbl[i].ed, tbl[i].epe, tbl[i].efe, tbl[i].ebrk};
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].pm, tbl[i].pbit,
                tbl[i].s1, tbl[i].two, tbl[i].s2, e);
    end

    // False start: 4-clk low glitch, then a clean frame
    x0 = xfers;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    chk("glitch no valid", 32'(rx_valid), 32'd0);
    chk("glitch no xfer", 32'(xfers - x0), 32'd0);
    run_frame("glitch_recover", 8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1,
              model(8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));

    // Config change mid-frame applies only to the next frame
    parity_mode = 2'd0;
    two_stop    = 1'b0;
    fork
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, period(), t0);
      begin
        repeat (40) @(negedge clk);
        parity_mode = 2'd1;
        two_stop    = 1'b1;
      end
    join
    wait_word("cfg_latch", ok);
    if (ok) begin
      $display("cfg_latch: data=%02h pe=%0d fe=%0d", rx_data, rx_par_err, rx_frame_err);
      chk("cfg_latch data", 32'(rx_data), 32'h96);
      chk("cfg_latch par_err", 32'(rx_par_err), 32'd0);
      accept("cfg_latch");
    end
    repeat (32) @(negedge clk);

    // Overrun: second frame dropped while the first is unaccepted
    parity_mode = 2'd0;
    two_stop    = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, period(), t0);
    wait_word("ovr_first", ok);
    chk("ovr first data", 32'(rx_data), 32'h11);
    o0 = ovr_pulses;
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, period(), t0);
    repeat (32) @(negedge clk);
    $display("overrun: data=%02h valid=%0d pulses=%0d", rx_data, rx_valid, ovr_pulses - o0);
    chk("ovr pulses", 32'(ovr_pulses - o0), 32'd1);
    chk("ovr data kept", 32'(rx_data), 32'h11);
    chk("ovr still valid", 32'(rx_valid), 32'd1);
    accept("ovr");

    // Break: line low for 20 bit times yields exactly one word
    x0 = xfers;
    o0 = ovr_pulses;
    rx_ready = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (20 * 16) @(negedge clk);
    rx = 1'b1;
    repeat (3 * 16) @(negedge clk);
    rx_ready = 1'b0;
    $display("break: words=%0d data=%02h brk=%0d fe=%0d", xfers - x0, last_data, last_brk, last_fe);
    chk("break words", 32'(xfers - x0), 32'd1);
    chk("break data", 32'(last_data), 32'h00);
    chk("break flag", 32'(last_brk), 32'd1);
    chk("break frame_err", 32'(last_fe), 32'd1);
    chk("break no overrun", 32'(ovr_pulses - o0), 32'd0);

    // enable dropped mid-data discards the partial word
    x0 = xfers;
    @(negedge clk);
    rx = 1'b0;
    repeat (16 * 4) @(negedge clk);
    enable = 1'b0;
    rx     = 1'b1;
    repeat (16 * 12) @(negedge clk);
    enable = 1'b1;
    repeat (16 * 12) @(negedge clk);
    $display("enable_abort: valid=%0d words=%0d", rx_valid, xfers - x0);
    chk("enable abort valid", 32'(rx_valid), 32'd0);
    chk("enable abort words", 32'(xfers - x0), 32'd0);

    // Reset mid-frame with a pending word
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, period(), t0);
    wait_word("rst_pending", ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (16 * 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset_mid: valid=%0d data=%02h", rx_valid, rx_data);
    chk("mid reset valid", 32'(rx_valid), 32'd0);
    chk("mid reset data", 32'(rx_data), 32'd0);
    chk("mid reset flags", {28'd0, rx_frame_err, rx_par_err, rx_break, rx_overrun}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (16 * 12) @(negedge clk);
    chk("after reset valid", 32'(rx_valid), 32'd0);

    // Randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      clk_div = 16'($urandom_range(0, 20));
      d       = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pm      = 2'($urandom_range(0, 3));
      two     = 1'($urandom_range(0, 1));
      good    = (pm == 2'd2) ? ~(^d) : ^d;
      pbit    = ($urandom_range(0, 3) == 0) ? ~good : good;
      s1      = ($urandom_range(0, 5) != 0);
      s2      = ($urandom_range(0, 5) != 0);
      run_frame($sformatf("rand%0d", n), d, pm, pbit, s1, two, s2,
                model(d, pm, pbit, s1, two, s2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
